// File: rtl/intr_arbiter_pkg.sv
// lib_intr: shared types and helpers for the interrupt arbiter slice.
//
// Contents:
//   intr_state_t  - grant FSM states (IDLE, PRESENT, RELEASE)
//   rr_pick_t     - result of a round-robin search {found, index}
//   rr_pick()     - finds the first eligible source scanning upward from a
//                   pointer, wrapping at n_src
//
// The helper is written against a fixed maximum of 16 sources, so one
// function body serves every arbiter size. Callers zero-extend their vectors
// to MAX_SRC / MAX_IDW bits before the call.
package lib_intr;

    localparam int MAX_SRC = 16;
    localparam int MAX_IDW = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        RELEASE = 2'd2
    } intr_state_t;

    typedef struct packed {
        logic               found;
        logic [MAX_IDW-1:0] index;
    } rr_pick_t;

    // Scan eligible starting at ptr, wrapping at n_src. Only the first
    // n_src positions of the scan are considered, so the bits above n_src-1
    // in eligible are never looked at.
    function automatic rr_pick_t rr_pick(
        input logic [MAX_SRC-1:0] eligible,
        input logic [MAX_IDW-1:0] ptr,
        input logic [MAX_IDW:0]   n_src
    );
        rr_pick_t         res;
        logic [MAX_IDW:0] idx;
        res.found = 1'b0;
        res.index = '0;
        for (int k = 0; k < MAX_SRC; k++) begin
            idx = {1'b0, ptr} + 5'(k);
            if (idx >= n_src) begin
                idx = idx - n_src;
            end
            if ((5'(k) < n_src) && !res.found && eligible[idx[MAX_IDW-1:0]]) begin
                res.found = 1'b1;
                res.index = idx[MAX_IDW-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/intr_arbiter_src_latch.sv
// intr_src_latch: per-source event latch for the interrupt arbiter.
//
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   req         - single-cycle event strobe from the peripheral
//   data        - payload, valid while req=1
//   clr         - arbiter has consumed this source's pending event
//   ovf_clr     - clears the sticky overflow flag
//   pend        - an event is waiting to be granted
//   data_buf    - payload of the waiting event
//   ovf         - sticky: an event arrived while one was already waiting
module intr_src_latch #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic [DW-1:0] data,
    input  logic          clr,
    input  logic          ovf_clr,
    output logic          pend,
    output logic [DW-1:0] data_buf,
    output logic          ovf
);

    // Pending/payload latch. The first event wins while one is waiting, but a
    // new event landing in the same cycle as the clear simply replaces the
    // consumed one (set wins over clear). An event that gets dropped raises
    // ovf, and that set also beats a simultaneous ovf_clr.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend     <= 1'b0;
            data_buf <= '0;
            ovf      <= 1'b0;
        end else begin
            if (req && (!pend || clr)) begin
                pend     <= 1'b1;
                data_buf <= data;
            end else if (clr) begin
                pend     <= 1'b0;
            end

            if (req && pend && !clr) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/intr_arbiter.sv
// intr_arbiter: shares the CPU's single interrupt input among N_SRC
// byte-producing peripherals, granting pending events round-robin.
//
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   src_req     - per-source event strobes
//   src_data    - per-source payloads, source i at [i*DW +: DW]
//   src_en      - per-source grant enables (masked sources still latch)
//   irr         - interrupt request to the CPU
//   ack         - CPU acknowledge (level, may stay high for many cycles)
//   r_data      - payload of the granted source, stable while irr=1
//   irq_id      - index of the granted source, stable while irr=1
//   ovf         - sticky per-source overflow flags
//   ovf_clr     - clears the matching ovf bits
module intr_arbiter
    import lib_intr::*;
#(
    parameter int N_SRC = 4,
    parameter int DW    = 8,
    parameter int IDW   = $clog2(N_SRC)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_SRC-1:0]    src_req,
    input  logic [N_SRC*DW-1:0] src_data,
    input  logic [N_SRC-1:0]    src_en,
    output logic                irr,
    input  logic                ack,
    output logic [DW-1:0]       r_data,
    output logic [IDW-1:0]      irq_id,
    output logic [N_SRC-1:0]    ovf,
    input  logic [N_SRC-1:0]    ovf_clr
);

    localparam logic [IDW-1:0] LAST_ID = IDW'(N_SRC - 1);

    intr_state_t      state, state_next;
    logic [IDW-1:0]   rr_ptr, rr_ptr_next;
    logic             irr_next;
    logic [IDW-1:0]   irq_id_next;
    logic [DW-1:0]    r_data_next;
    logic [N_SRC-1:0] pend;
    logic [N_SRC-1:0] clr;
    logic [DW-1:0]    data_buf [N_SRC];
    rr_pick_t         pick;
    logic [IDW-1:0]   pick_id;

    genvar gi;
    generate
        for (gi = 0; gi < N_SRC; gi++) begin : g_src
            intr_src_latch #(.DW(DW)) u_latch (
                .clk      (clk),
                .reset    (reset),
                .req      (src_req[gi]),
                .data     (src_data[gi*DW +: DW]),
                .clr      (clr[gi]),
                .ovf_clr  (ovf_clr[gi]),
                .pend     (pend[gi]),
                .data_buf (data_buf[gi]),
                .ovf      (ovf[gi])
            );
        end
    endgenerate

    // Round-robin candidate among pending, enabled sources. Only consulted
    // in IDLE, so enable changes never revoke a grant already presented.
    always_comb begin
        pick    = rr_pick(MAX_SRC'(pend & src_en), MAX_IDW'(rr_ptr), 5'(N_SRC));
        pick_id = IDW'(pick.index);
    end

    // Grant FSM. PRESENT holds irr/irq_id/r_data until ack; the pending bit is
    // cleared on that ack cycle. RELEASE then waits for ack to drop so a long
    // ack cannot also swallow the next grant.
    always_comb begin
        state_next  = state;
        irr_next    = irr;
        irq_id_next = irq_id;
        r_data_next = r_data;
        rr_ptr_next = rr_ptr;
        clr         = '0;
        case (state)
            IDLE: begin
                if (pick.found) begin
                    irr_next    = 1'b1;
                    irq_id_next = pick_id;
                    r_data_next = data_buf[pick_id];
                    state_next  = PRESENT;
                end
            end
            PRESENT: begin
                if (ack) begin
                    clr[irq_id] = 1'b1;
                    irr_next    = 1'b0;
                    rr_ptr_next = (irq_id == LAST_ID) ? '0 : irq_id + IDW'(1);
                    state_next  = RELEASE;
                end
            end
            RELEASE: begin
                if (!ack) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any grant in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            rr_ptr <= '0;
            irr    <= 1'b0;
            irq_id <= '0;
            r_data <= '0;
        end else begin
            state  <= state_next;
            rr_ptr <= rr_ptr_next;
            irr    <= irr_next;
            irq_id <= irq_id_next;
            r_data <= r_data_next;
        end
    end

endmodule
